// File: rtl/battle_datapath.sv
// Battle datapath: HP registers, move selection and a shift-add damage multiplier.
// Optional critical hits (LFSR-driven damage doubling) are enabled by defining PBS_CRIT_EN.
module battle_datapath #(
  parameter int HP_W       = 4,
  parameter int ATK_W      = 4,
  parameter int P_ATK      = 3,
  parameter int AI_ATK     = 2,
  parameter int DMG_SHIFT  = 1,
  parameter int P_HP_INIT  = 15,
  parameter int AI_HP_INIT = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ld_move,
  input  logic [1:0]      move_in,
  input  logic            calc_damage,
  input  logic            active_trainer,
  input  logic            target,
  input  logic            apply_damage,
  output logic            dmg_busy,
  output logic            dmg_valid,
  output logic [HP_W-1:0] damage,
  output logic [HP_W-1:0] p_hp,
  output logic [HP_W-1:0] ai_hp,
  output logic            hp_is_zero,
  output logic            crit
);

  localparam int PROD_W = 2 * ATK_W;
  localparam int CNT_W  = (ATK_W > 1) ? $clog2(ATK_W) : 1;
  localparam logic [HP_W-1:0] HP_MAX = {HP_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [HP_W-1:0]    p_hp_q, p_hp_d;
  logic [HP_W-1:0]    ai_hp_q, ai_hp_d;
  logic [HP_W-1:0]    damage_q, damage_d;
  logic               dmg_valid_q, dmg_valid_d;
  logic               crit_q, crit_d;
  logic               crit_flag_q, crit_flag_d;
  logic [1:0]         move_q, move_d;
  logic [1:0]         ai_move_q, ai_move_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ATK_W-1:0]   atk_q, atk_d;
  logic [PROD_W-1:0]  mcand_q, mcand_d;
  logic [PROD_W-1:0]  prod_q, prod_d;
  logic               start_s;
  logic [1:0]         sel_move_s;
  logic [HP_W-1:0]    clamped_s;

  function automatic logic [3:0] move_power(input logic [1:0] mv);
    case (mv)
      2'd0:    move_power = 4'd2;
      2'd1:    move_power = 4'd3;
      2'd2:    move_power = 4'd4;
      2'd3:    move_power = 4'd1;
      default: move_power = 4'd0;
    endcase
  endfunction

  // Scale the raw product and clamp into [1, HP_MAX]; a hit always does something.
  function automatic logic [HP_W-1:0] clamp_damage(input logic [PROD_W-1:0] prod);
    logic [PROD_W-1:0] sh;
    sh = prod >> DMG_SHIFT;
    if (sh == {PROD_W{1'b0}}) begin
      clamp_damage = HP_W'(1);
    end else if (sh > PROD_W'(HP_MAX)) begin
      clamp_damage = HP_MAX;
    end else begin
      clamp_damage = sh[HP_W-1:0];
    end
  endfunction

  function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] hp,
                                              input logic [HP_W-1:0] dmg);
    if (hp < dmg) begin
      sat_sub = {HP_W{1'b0}};
    end else begin
      sat_sub = hp - dmg;
    end
  endfunction

`ifdef PBS_CRIT_EN
  logic [3:0] lfsr_q, lfsr_d;

  function automatic logic [HP_W-1:0] dbl_sat(input logic [HP_W-1:0] d);
    logic [HP_W:0] t;
    t = {d, 1'b0};
    if (t[HP_W]) begin
      dbl_sat = HP_MAX;
    end else begin
      dbl_sat = t[HP_W-1:0];
    end
  endfunction

  // Free-running x^4+x^3+1 LFSR next-state.
  always_comb begin
    lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
  end

  // LFSR register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= 4'b1001;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end
`endif

  assign sel_move_s = active_trainer ? ai_move_q : move_q;
  assign start_s    = (state_q == IDLE) && calc_damage && !dmg_valid_q;
  assign clamped_s  = clamp_damage(prod_q);

  // Next-state: move capture, multiplier sequencing, damage latch and HP update.
  always_comb begin
    state_d     = state_q;
    p_hp_d      = p_hp_q;
    ai_hp_d     = ai_hp_q;
    damage_d    = damage_q;
    dmg_valid_d = dmg_valid_q;
    crit_d      = crit_q;
    crit_flag_d = crit_flag_q;
    move_d      = move_q;
    ai_move_d   = ai_move_q;
    cnt_d       = cnt_q;
    atk_d       = atk_q;
    mcand_d     = mcand_q;
    prod_d      = prod_q;

    if (ld_move) begin
      move_d = move_in;
    end else begin
      move_d = move_q;
    end

    case (state_q)
      IDLE: begin
        if (start_s) begin
          mcand_d = PROD_W'(move_power(sel_move_s));
          atk_d   = active_trainer ? ATK_W'(AI_ATK) : ATK_W'(P_ATK);
          prod_d  = {PROD_W{1'b0}};
          cnt_d   = {CNT_W{1'b0}};
          state_d = MUL;
`ifdef PBS_CRIT_EN
          crit_flag_d = (lfsr_q[1:0] == 2'b00);
`else
          crit_flag_d = 1'b0;
`endif
          if (active_trainer) begin
            ai_move_d = ai_move_q + 2'd1;
          end else begin
            ai_move_d = ai_move_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MUL: begin
        if (atk_q[0]) begin
          prod_d = prod_q + mcand_q;
        end else begin
          prod_d = prod_q;
        end
        mcand_d = mcand_q << 1;
        atk_d   = atk_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(ATK_W - 1)) begin
          state_d = DONE;
        end else begin
          state_d = MUL;
        end
      end
      DONE: begin
`ifdef PBS_CRIT_EN
        damage_d = crit_flag_q ? dbl_sat(clamped_s) : clamped_s;
`else
        damage_d = clamped_s;
`endif
        crit_d      = crit_flag_q;
        dmg_valid_d = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Valid is never set in DONE while already high, so apply cannot race the latch.
    if (apply_damage && dmg_valid_q) begin
      dmg_valid_d = 1'b0;
      if (target) begin
        ai_hp_d = sat_sub(ai_hp_q, damage_q);
      end else begin
        p_hp_d = sat_sub(p_hp_q, damage_q);
      end
    end else begin
      p_hp_d  = p_hp_d;
      ai_hp_d = ai_hp_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      p_hp_q      <= HP_W'(P_HP_INIT);
      ai_hp_q     <= HP_W'(AI_HP_INIT);
      damage_q    <= {HP_W{1'b0}};
      dmg_valid_q <= 1'b0;
      crit_q      <= 1'b0;
      crit_flag_q <= 1'b0;
      move_q      <= 2'd0;
      ai_move_q   <= 2'd0;
      cnt_q       <= {CNT_W{1'b0}};
      atk_q       <= {ATK_W{1'b0}};
      mcand_q     <= {PROD_W{1'b0}};
      prod_q      <= {PROD_W{1'b0}};
    end else begin
      state_q     <= state_d;
      p_hp_q      <= p_hp_d;
      ai_hp_q     <= ai_hp_d;
      damage_q    <= damage_d;
      dmg_valid_q <= dmg_valid_d;
      crit_q      <= crit_d;
      crit_flag_q <= crit_flag_d;
      move_q      <= move_d;
      ai_move_q   <= ai_move_d;
      cnt_q       <= cnt_d;
      atk_q       <= atk_d;
      mcand_q     <= mcand_d;
      prod_q      <= prod_d;
    end
  end

  assign dmg_busy   = (state_q == MUL);
  assign dmg_valid  = dmg_valid_q;
  assign damage     = damage_q;
  assign p_hp       = p_hp_q;
  assign ai_hp      = ai_hp_q;
  assign crit       = crit_q;
  assign hp_is_zero = target ? (ai_hp_q == {HP_W{1'b0}}) : (p_hp_q == {HP_W{1'b0}});

endmodule
